// File: rtl/sp_ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sp_ram_arb_pkg
// Shared types and constants for the single-port RAM arbiter.
//   owner_e        : which port owns the access issued in the previous cycle
//   STARVE_W       : width of the per-port starvation counters
//   STARVE_THRESH  : counter value at which a losing port is forced to win
// -----------------------------------------------------------------------------
package sp_ram_arb_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_INSTR = 2'd1,
    OWNER_DATA  = 2'd2
  } owner_e;

  localparam int unsigned STARVE_W = 2;
  localparam logic [STARVE_W-1:0] STARVE_THRESH = 2'd3;

endpackage

// File: rtl/sp_ram_arb_prio.sv
// -----------------------------------------------------------------------------
// sp_ram_arb_prio
// Grant selection between the instruction and data ports.
//   - No contention: the single requester is granted combinationally.
//   - Contention: a port whose starvation counter has reached STARVE_THRESH
//     wins; otherwise the data port wins (fixed priority) or, with
//     ARB_ROUND_ROBIN_EN defined, the port not granted at the last contention.
//   - Each port's counter counts consecutive cycles of requesting and losing,
//     and clears whenever that port is granted.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin contention).
//
// Ports
//   clk          in   rising-edge clock
//   rst_i        in   synchronous active-high reset; forces grants to 0
//   instr_req_i  in   instruction port request
//   data_req_i   in   data port request
//   instr_gnt_o  out  instruction port grant (combinational)
//   data_gnt_o   out  data port grant (combinational)
// -----------------------------------------------------------------------------
module sp_ram_arb_prio
  import sp_ram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_i,
  input  logic instr_req_i,
  input  logic data_req_i,
  output logic instr_gnt_o,
  output logic data_gnt_o
);

  logic [STARVE_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [STARVE_W-1:0] data_cnt_q, data_cnt_d;
  logic                contend;
  logic                instr_starved;
  logic                data_starved;
  logic                favour_data;

  assign contend       = instr_req_i & data_req_i;
  assign instr_starved = (instr_cnt_q == STARVE_THRESH);
  assign data_starved  = (data_cnt_q == STARVE_THRESH);

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data port wins the next plain contention. Only a contended grant
  // moves it, and it always moves to the port that just lost.
  logic ptr_data_q, ptr_data_d;

  assign favour_data = ptr_data_q;

  always_comb begin
    ptr_data_d = ptr_data_q;
    if (contend && !rst_i) begin
      ptr_data_d = instr_gnt_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      ptr_data_q <= 1'b1;
    end else begin
      ptr_data_q <= ptr_data_d;
    end
  end
`else
  assign favour_data = 1'b1;
`endif

  always_comb begin
    instr_gnt_o = 1'b0;
    data_gnt_o  = 1'b0;
    if (!rst_i) begin
      if (contend) begin
        // The starvation override only applies when exactly one port is
        // starved; a tie falls back to the normal contention rule.
        if (instr_starved && !data_starved) begin
          instr_gnt_o = 1'b1;
        end else if (data_starved && !instr_starved) begin
          data_gnt_o = 1'b1;
        end else if (favour_data) begin
          data_gnt_o = 1'b1;
        end else begin
          instr_gnt_o = 1'b1;
        end
      end else begin
        instr_gnt_o = instr_req_i;
        data_gnt_o  = data_req_i;
      end
    end
  end

  // A request that is not granted has lost to the other port; counters
  // saturate at the threshold until the port is granted.
  always_comb begin
    instr_cnt_d = instr_cnt_q;
    data_cnt_d  = data_cnt_q;
    if (instr_gnt_o) begin
      instr_cnt_d = '0;
    end else if (instr_req_i && !instr_starved) begin
      instr_cnt_d = instr_cnt_q + 1'b1;
    end
    if (data_gnt_o) begin
      data_cnt_d = '0;
    end else if (data_req_i && !data_starved) begin
      data_cnt_d = data_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      instr_cnt_q <= '0;
      data_cnt_q  <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      data_cnt_q  <= data_cnt_d;
    end
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// -----------------------------------------------------------------------------
// sp_ram_arbiter
// Shares one single-port RAM between an instruction port (read only) and a
// data port (read/write). One access per cycle; grant selection lives in
// sp_ram_arb_prio, this level muxes the granted payload onto the RAM and
// routes the response back one cycle later.
//
// Handshake: a requester raises req with its payload and holds both stable
// until it sees gnt in the same cycle; the access is then on the RAM that
// cycle, and exactly one cycle later the owning port sees rvalid for one
// cycle (reads carry ram_rdata_i, data-port writes carry don't-care data).
// gnt and rvalid may coincide, so back-to-back accesses run at full rate.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin contention,
// handled inside sp_ram_arb_prio).
//
// Ports
//   clk, rst_i                          clock, synchronous active-high reset
//   instr_req_i/instr_addr_i            instruction read request, byte address
//   instr_gnt_o/instr_rvalid_o/_rdata_o instruction grant and read response
//   data_req_i/_we_i/_addr_i/_be_i/_wdata_i   data request and payload
//   data_gnt_o/data_rvalid_o/data_rdata_o     data grant and response
//   ram_en_o/_we_o/_addr_o/_be_o/_wdata_o     RAM-side access
//   ram_rdata_i                         RAM read data, one cycle after ram_en_o
//   ram_bypass_o                        RAM test bypass, tied low
// -----------------------------------------------------------------------------
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    ram_en_o,
  output logic                    ram_we_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
  output logic                    ram_bypass_o
);

  owner_e owner_q, owner_d;

  sp_ram_arb_prio u_prio (
    .clk         (clk),
    .rst_i       (rst_i),
    .instr_req_i (instr_req_i),
    .data_req_i  (data_req_i),
    .instr_gnt_o (instr_gnt_o),
    .data_gnt_o  (data_gnt_o)
  );

  // When idle the data payload is left on the RAM bus; only ram_en_o and
  // ram_we_o are meaningful then.
  always_comb begin
    ram_en_o = instr_gnt_o | data_gnt_o;
    if (instr_gnt_o) begin
      ram_we_o    = 1'b0;
      ram_addr_o  = instr_addr_i;
      ram_be_o    = '1;
      ram_wdata_o = '0;
    end else begin
      ram_we_o    = data_gnt_o & data_we_i;
      ram_addr_o  = data_addr_i;
      ram_be_o    = data_be_i;
      ram_wdata_o = data_wdata_i;
    end
  end

  always_comb begin
    owner_d = OWNER_NONE;
    if (data_gnt_o) begin
      owner_d = OWNER_DATA;
    end else if (instr_gnt_o) begin
      owner_d = OWNER_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      owner_q <= OWNER_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // rst_i also gates rvalid so a grant made just before reset never
  // produces a response while reset is held.
  assign instr_rvalid_o = !rst_i && (owner_q == OWNER_INSTR);
  assign data_rvalid_o  = !rst_i && (owner_q == OWNER_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? ram_rdata_i : '0;
  assign data_rdata_o   = data_rvalid_o ? ram_rdata_i : '0;
  assign ram_bypass_o   = 1'b0;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sp_ram_arbiter
// Bench for sp_ram_arbiter with a behavioural RAM attached to the RAM side.
// Directed scenarios cover reset, single reads/writes, contention patterns
// and reset during an outstanding response; a randomized run compares every
// cycle against a reference model of the arbitration rules and a shadow
// copy of memory contents.
// -----------------------------------------------------------------------------
module tb_sp_ram_arbiter;
  import sp_ram_arb_pkg::*;

  localparam int AW = 15;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          instr_req_i;
  logic [AW-1:0] instr_addr_i;
  logic          instr_gnt_o, instr_rvalid_o;
  logic [DW-1:0] instr_rdata_o;
  logic          data_req_i, data_we_i;
  logic [AW-1:0] data_addr_i;
  logic [3:0]    data_be_i;
  logic [DW-1:0] data_wdata_i;
  logic          data_gnt_o, data_rvalid_o;
  logic [DW-1:0] data_rdata_o;
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [3:0]    ram_be_o;
  logic [DW-1:0] ram_wdata_o;
  logic [DW-1:0] ram_rdata_i = '0;
  logic          ram_bypass_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] ram_mem [0:8191];
  logic [DW-1:0] ref_mem [0:8191];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ram_tmp;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst_i          (rst_i),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_addr_i    (data_addr_i),
    .data_be_i      (data_be_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .ram_en_o       (ram_en_o),
    .ram_we_o       (ram_we_o),
    .ram_addr_o     (ram_addr_o),
    .ram_be_o       (ram_be_o),
    .ram_wdata_o    (ram_wdata_o),
    .ram_rdata_i    (ram_rdata_i),
    .ram_bypass_o   (ram_bypass_o)
  );

  // Behavioural single-port RAM: read-before-write, data one cycle later.
  always @(posedge clk) begin
    if (ram_en_o) begin
      ram_rdata_i <= ram_mem[ram_addr_o[AW-1:2]];
      if (ram_we_o) begin
        ram_tmp = ram_mem[ram_addr_o[AW-1:2]];
        for (int b = 0; b < 4; b++) begin
          if (ram_be_o[b]) ram_tmp[8*b +: 8] = ram_wdata_o[8*b +: 8];
        end
        ram_mem[ram_addr_o[AW-1:2]] = ram_tmp;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ir, input logic [AW-1:0] ia,
                       input logic dr, input logic dwe, input logic [AW-1:0] da,
                       input logic [3:0] dbe, input logic [DW-1:0] dwd);
    @(negedge clk);
    instr_req_i  = ir;
    instr_addr_i = ia;
    data_req_i   = dr;
    data_we_i    = dwe;
    data_addr_i  = da;
    data_be_i    = dbe;
    data_wdata_i = dwd;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_i = 1'b1;
    instr_req_i = 1'b0;
    data_req_i  = 1'b0;
    data_we_i   = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_i = 1'b1;
    instr_req_i = 1'b1; instr_addr_i = 15'h0010;
    data_req_i  = 1'b1; data_we_i = 1'b1; data_addr_i = 15'h0020;
    data_be_i   = 4'hF; data_wdata_i = 32'h1;
    @(negedge clk);
    #1;
    n_cmp++; if ({instr_gnt_o, data_gnt_o} !== 2'b00) begin n_fail++; $display("FAIL rst_gnt got=%b required=00", {instr_gnt_o, data_gnt_o}); end
    n_cmp++; if ({ram_en_o, ram_we_o} !== 2'b00) begin n_fail++; $display("FAIL rst_ram_en_we got=%b required=00", {ram_en_o, ram_we_o}); end
    n_cmp++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid got=%b required=00", {instr_rvalid_o, data_rvalid_o}); end
    n_cmp++; if (ram_bypass_o !== 1'b0) begin n_fail++; $display("FAIL rst_bypass got=%b required=0", ram_bypass_o); end
    n_cmp++; if (dut.owner_q !== OWNER_NONE) begin n_fail++; $display("FAIL rst_owner got=%0d required=%0d", dut.owner_q, OWNER_NONE); end
    instr_req_i = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic test_instr_read();
    apply_reset();
    ram_mem[1] = 32'hDEADBEEF; ref_mem[1] = 32'hDEADBEEF;
    drive(1'b1, 15'h0004, 1'b0, 1'b0, '0, 4'h0, '0);
    n_cmp++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin n_fail++; $display("FAIL ird_gnt got=%b required=10", {instr_gnt_o, data_gnt_o}); end
    n_cmp++; if ({ram_en_o, ram_we_o} !== 2'b10) begin n_fail++; $display("FAIL ird_ram_en_we got=%b required=10", {ram_en_o, ram_we_o}); end
    n_cmp++; if (ram_be_o !== 4'hF) begin n_fail++; $display("FAIL ird_be got=%h required=f", ram_be_o); end
    n_cmp++; if (ram_addr_o !== 15'h0004) begin n_fail++; $display("FAIL ird_addr got=%h required=0004", ram_addr_o); end
    drive(1'b0, '0, 1'b0, 1'b0, '0, 4'h0, '0);
    n_cmp++; if (instr_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL ird_rvalid got=%b required=1", instr_rvalid_o); end
    n_cmp++; if (instr_rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ird_rdata got=%h required=deadbeef", instr_rdata_o); end
    n_cmp++; if (data_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL ird_drvalid got=%b required=0", data_rvalid_o); end
    n_cmp++; if (data_rdata_o !== 32'h0) begin n_fail++; $display("FAIL ird_drdata got=%h required=0", data_rdata_o); end
    drive(1'b0, '0, 1'b0, 1'b0, '0, 4'h0, '0);
    n_cmp++; if (instr_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL ird_rvalid_once got=%b required=0", instr_rvalid_o); end
  endtask

  task automatic test_data_write_read();
    apply_reset();
    ram_mem[2048] = 32'hAAAA5555; ref_mem[2048] = 32'hAAAA5555;
    drive(1'b0, '0, 1'b1, 1'b1, 15'h2000, 4'b0011, 32'h00001234);
    n_cmp++; if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin n_fail++; $display("FAIL dwr_gnt got=%b required=01", {instr_gnt_o, data_gnt_o}); end
    n_cmp++; if ({ram_en_o, ram_we_o} !== 2'b11) begin n_fail++; $display("FAIL dwr_ram_en_we got=%b required=11", {ram_en_o, ram_we_o}); end
    n_cmp++; if (ram_be_o !== 4'b0011) begin n_fail++; $display("FAIL dwr_be got=%b required=0011", ram_be_o); end
    n_cmp++; if (ram_addr_o !== 15'h2000 || ram_wdata_o !== 32'h1234) begin n_fail++; $display("FAIL dwr_payload got=%h/%h required=2000/00001234", ram_addr_o, ram_wdata_o); end
    drive(1'b0, '0, 1'b1, 1'b0, 15'h2000, 4'hF, '0);
    n_cmp++; if (data_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL dwr_wr_rvalid got=%b required=1", data_rvalid_o); end
    n_cmp++; if ({data_gnt_o, ram_we_o} !== 2'b10) begin n_fail++; $display("FAIL drd_gnt_we got=%b required=10", {data_gnt_o, ram_we_o}); end
    drive(1'b0, '0, 1'b0, 1'b0, '0, 4'h0, '0);
    n_cmp++; if (data_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL drd_rvalid got=%b required=1", data_rvalid_o); end
    n_cmp++; if (data_rdata_o !== 32'hAAAA1234) begin n_fail++; $display("FAIL drd_rdata got=%h required=aaaa1234", data_rdata_o); end
    n_cmp++; if (instr_rvalid_o !== 1'b0 || instr_rdata_o !== 32'h0) begin n_fail++; $display("FAIL drd_instr_side got=%b/%h required=0/0", instr_rvalid_o, instr_rdata_o); end
    ref_mem[2048] = 32'hAAAA1234;
  endtask

  task automatic test_contention();
    logic exp_d;
    logic prev_d;
    apply_reset();
    prev_d = 1'b0;
    for (int k = 0; k < 8; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = (k % 4 != 3);
`endif
      drive(1'b1, 15'h0008, 1'b1, 1'b0, 15'h000C, 4'hF, '0);
      n_cmp++; if ({instr_gnt_o, data_gnt_o} !== {~exp_d, exp_d}) begin n_fail++; $display("FAIL cont_gnt cyc=%0d got=%b required=%b", k, {instr_gnt_o, data_gnt_o}, {~exp_d, exp_d}); end
      if (k > 0) begin
        n_cmp++; if ({instr_rvalid_o, data_rvalid_o} !== {~prev_d, prev_d}) begin n_fail++; $display("FAIL cont_rvalid cyc=%0d got=%b required=%b", k, {instr_rvalid_o, data_rvalid_o}, {~prev_d, prev_d}); end
      end
      prev_d = exp_d;
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, 4'h0, '0);
  endtask

  task automatic test_reset_after_grant();
    logic [2:0] exp_d;
    apply_reset();
    drive(1'b1, 15'h0008, 1'b1, 1'b0, 15'h000C, 4'hF, '0);
    drive(1'b0, '0, 1'b1, 1'b0, 15'h0010, 4'hF, '0);
    n_cmp++; if (data_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rag_gnt got=%b required=1", data_gnt_o); end
    @(negedge clk);
    rst_i = 1'b1; instr_req_i = 1'b0; data_req_i = 1'b0;
    #1;
    n_cmp++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin n_fail++; $display("FAIL rag_rvalid_in_rst got=%b required=00", {instr_rvalid_o, data_rvalid_o}); end
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    n_cmp++; if (dut.owner_q !== OWNER_NONE) begin n_fail++; $display("FAIL rag_owner got=%0d required=%0d", dut.owner_q, OWNER_NONE); end
    n_cmp++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin n_fail++; $display("FAIL rag_rvalid_after got=%b required=00", {instr_rvalid_o, data_rvalid_o}); end
`ifdef ARB_ROUND_ROBIN_EN
    exp_d = 3'b101;
`else
    exp_d = 3'b111;
`endif
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 15'h0008, 1'b1, 1'b0, 15'h000C, 4'hF, '0);
      n_cmp++; if ({instr_gnt_o, data_gnt_o} !== {~exp_d[k], exp_d[k]}) begin n_fail++; $display("FAIL rag_cont cyc=%0d got=%b required=%b", k, {instr_gnt_o, data_gnt_o}, {~exp_d[k], exp_d[k]}); end
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, 4'h0, '0);
  endtask

  // Reference model: each port's lose streak (capped at 3) decides the
  // override; otherwise data wins, or in round-robin mode the loser of the
  // previous contention wins.
  task automatic test_random();
    logic          ip, dp, dwe, e_ig, e_dg, prev_read;
    logic [AW-1:0] ia, da;
    logic [3:0]    dbe;
    logic [DW-1:0] dwd, exp_rd, w;
    int            i_lose, d_lose, last_win, prev_own;
    apply_reset();
    exp_q.delete();
    ip = 0; dp = 0; dwe = 0; ia = '0; da = '0; dbe = '0; dwd = '0;
    i_lose = 0; d_lose = 0; last_win = 1; prev_own = 0; prev_read = 0;
    for (int c = 0; c < 600; c++) begin
      if (!ip && $urandom_range(0, 99) < 60) begin
        ip = 1; ia = {9'd0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (!dp && $urandom_range(0, 99) < 60) begin
        dp = 1; dwe = 1'($urandom_range(0, 1));
        da = {9'd0, 4'($urandom_range(0, 15)), 2'b00};
        dbe = 4'($urandom_range(0, 15)); dwd = $urandom;
      end
      drive(ip, ia, dp, dwe, da, dbe, dwd);

      // responses to last cycle's grant
      n_cmp++; if (instr_rvalid_o !== (prev_own == 1)) begin n_fail++; $display("FAIL rnd_irvalid cyc=%0d got=%b required=%b", c, instr_rvalid_o, prev_own == 1); end
      n_cmp++; if (data_rvalid_o !== (prev_own == 2)) begin n_fail++; $display("FAIL rnd_drvalid cyc=%0d got=%b required=%b", c, data_rvalid_o, prev_own == 2); end
      if (prev_own != 0 && prev_read) begin
        exp_rd = exp_q.pop_front();
        n_cmp++;
        if ((prev_own == 1 ? instr_rdata_o : data_rdata_o) !== exp_rd) begin
          n_fail++; $display("FAIL rnd_rdata cyc=%0d port=%0d got=%h required=%h", c, prev_own, (prev_own == 1 ? instr_rdata_o : data_rdata_o), exp_rd);
        end
      end
      if (prev_own != 1) begin
        n_cmp++; if (instr_rdata_o !== '0) begin n_fail++; $display("FAIL rnd_irdata_zero cyc=%0d got=%h required=0", c, instr_rdata_o); end
      end

      // expected arbitration this cycle
      e_ig = 0; e_dg = 0;
      if (ip && dp) begin
        if (i_lose >= 3 && d_lose < 3) e_ig = 1;
        else if (d_lose >= 3 && i_lose < 3) e_dg = 1;
        else begin
`ifdef ARB_ROUND_ROBIN_EN
          if (last_win == 2) e_ig = 1; else e_dg = 1;
`else
          e_dg = 1;
`endif
        end
        last_win = e_ig ? 1 : 2;
      end else begin
        e_ig = ip; e_dg = dp;
      end
      n_cmp++; if ({instr_gnt_o, data_gnt_o, ram_en_o} !== {e_ig, e_dg, e_ig | e_dg}) begin n_fail++; $display("FAIL rnd_gnt cyc=%0d got=%b required=%b", c, {instr_gnt_o, data_gnt_o, ram_en_o}, {e_ig, e_dg, e_ig | e_dg}); end
      if (e_ig) begin
        n_cmp++; if ({ram_addr_o, ram_we_o, ram_be_o} !== {ia, 1'b0, 4'hF}) begin n_fail++; $display("FAIL rnd_iram cyc=%0d got=%h/%b/%h required=%h/0/f", c, ram_addr_o, ram_we_o, ram_be_o, ia); end
      end
      if (e_dg) begin
        n_cmp++; if ({ram_addr_o, ram_we_o, ram_be_o} !== {da, dwe, dbe}) begin n_fail++; $display("FAIL rnd_dram cyc=%0d got=%h/%b/%h required=%h/%b/%h", c, ram_addr_o, ram_we_o, ram_be_o, da, dwe, dbe); end
        if (dwe) begin
          n_cmp++; if (ram_wdata_o !== dwd) begin n_fail++; $display("FAIL rnd_wdata cyc=%0d got=%h required=%h", c, ram_wdata_o, dwd); end
        end
      end

      // advance the model
      i_lose = e_ig ? 0 : (ip ? (i_lose < 3 ? i_lose + 1 : 3) : i_lose);
      d_lose = e_dg ? 0 : (dp ? (d_lose < 3 ? d_lose + 1 : 3) : d_lose);
      prev_own  = e_dg ? 2 : (e_ig ? 1 : 0);
      prev_read = e_ig || (e_dg && !dwe);
      if (e_ig) begin
        exp_q.push_back(ref_mem[ia[AW-1:2]]);
        ip = 0;
      end
      if (e_dg) begin
        if (!dwe) exp_q.push_back(ref_mem[da[AW-1:2]]);
        else begin
          w = ref_mem[da[AW-1:2]];
          for (int b = 0; b < 4; b++) if (dbe[b]) w[8*b +: 8] = dwd[8*b +: 8];
          ref_mem[da[AW-1:2]] = w;
        end
        dp = 0;
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, 4'h0, '0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    logic [DW-1:0] v;
    rst_i = 1'b1;
    instr_req_i = 0; instr_addr_i = '0;
    data_req_i = 0; data_we_i = 0; data_addr_i = '0; data_be_i = '0; data_wdata_i = '0;
    for (int i = 0; i < 8192; i++) begin
      v = $urandom;
      ram_mem[i] = v;
      ref_mem[i] = v;
    end
    test_reset();
    test_instr_read();
    test_data_write_read();
    test_contention();
    test_reset_after_grant();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_ram_arbiter.md
SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 15: byte-address width of the shared single-port RAM (32 KiB).
REQ-002 Parameter DATA_WIDTH, default 32: data width; byte enables are DATA_WIDTH/8 bits wide.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 instr_req_i / instr_addr_i  input  1 / ADDR_WIDTH  instruction-port read request and byte address.
REQ-006 instr_gnt_o / instr_rvalid_o / instr_rdata_o  output  1 / 1 / DATA_WIDTH  instruction-port grant, read-valid and read data.
REQ-007 data_req_i / data_we_i / data_addr_i / data_be_i / data_wdata_i  input  1 / 1 / ADDR_WIDTH / DATA_WIDTH/8 / DATA_WIDTH  data-port request, write enable, address, byte enables and write data.
REQ-008 data_gnt_o / data_rvalid_o / data_rdata_o  output  1 / 1 / DATA_WIDTH  data-port grant, response-valid and read data.
REQ-009 ram_en_o / ram_we_o / ram_addr_o / ram_be_o / ram_wdata_o  output  1 / 1 / ADDR_WIDTH / DATA_WIDTH/8 / DATA_WIDTH  RAM-side request; ram_rdata_i  input  DATA_WIDTH  RAM read data, valid one cycle after ram_en_o.
REQ-010 ram_bypass_o  output  1  RAM test bypass; constant 0.

Function
REQ-011 The block shall grant at most one port per cycle; a grant is combinational in the cycle the granted req is high.
REQ-012 The granted port's address, we, be and wdata shall be driven to the RAM combinationally in the grant cycle, with ram_en_o=1; the instruction port shall always drive ram_we_o=0 and ram_be_o all-ones.
REQ-013 With no request, ram_en_o=0, ram_we_o=0, and the ram_addr_o/ram_be_o/ram_wdata_o values are don't-care.
REQ-014 Requesters shall hold req and payload stable until gnt; the arbiter need not tolerate withdrawal before grant.
REQ-015 A registered owner field {NONE, INSTR, DATA} shall record the grant; in the next cycle exactly the owner's rvalid shall be 1 for one cycle.
REQ-016 rdata outputs shall be ram_rdata_i for the owner's port and zero for the other port; data_rvalid_o shall also pulse for writes, with data_rdata_o then don't-care.
REQ-017 Throughput shall be one access per cycle; back-to-back grants to any port are legal, and a new grant may coincide with the previous rvalid.
REQ-018 Under contention without ARB_ROUND_ROBIN_EN, the data port shall always win.
REQ-019 A 2-bit per-port starvation counter shall increment each cycle its port requests and loses; at count 3 that port shall win the next contention and its counter shall clear; a grant also clears it.

Reset
REQ-020 While rst_i=1: all gnt, rvalid, ram_en_o and ram_we_o outputs shall be 0, owner=NONE, starvation counters=0, and the priority pointer shall favour the data port.
REQ-021 Reset asserted in the cycle after a grant shall suppress that grant's rvalid; no response shall be issued after reset.

Configuration
REQ-022 With macro ARB_ROUND_ROBIN_EN defined, contention shall be resolved round-robin: the port not granted last wins, and the pointer shall update only on a contended grant; REQ-019 still applies.
REQ-023 With ARB_ROUND_ROBIN_EN undefined, fixed priority per REQ-018 plus starvation override per REQ-019 shall apply, and no pointer register shall exist.

Structure
REQ-024 Package sp_ram_arb_pkg shall hold the owner enum (NONE, INSTR, DATA), the starvation threshold constant (3) and the starvation counter width (2).
REQ-025 Priority selection, including the pointer, counters and override, shall live in sub-module sp_ram_arb_prio; the top shall contain muxing and owner/rvalid registers only.

Verification
REQ-026 Instr-only read at 0x0004, RAM word 0xDEADBEEF -> instr_gnt_o in cycle 0, instr_rvalid_o and instr_rdata_o=0xDEADBEEF in cycle 1, data_rvalid_o=0.
REQ-027 Data write 0x0000_1234 to 0x2000 with be=4'b0011, then a read of the same address -> ram_we_o=1 and ram_be_o=4'b0011 in the write cycle, data_rvalid_o in each following cycle, read returns 0x1234 in the low 16 bits.
REQ-028 Both ports request continuously for 8 cycles (fixed priority) -> data granted in cycles 0-2, instr in cycle 3, pattern repeats; no cycle has two grants.
REQ-029 Same stimulus with ARB_ROUND_ROBIN_EN -> grants alternate DATA, INSTR, DATA, INSTR, ...
REQ-030 rst_i asserted in the cycle after a data read grant -> data_rvalid_o stays 0, owner=NONE, and the first post-reset contention grants data.
